// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller: FSM state encoding, balance
// select codes, item/coin code constants and price/coin value lookups.
package vend_pkg;

  localparam int TIMER_W = 8;
  localparam logic [7:0] BAL_MAX = 8'd119;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    LOAD_PRICE = 4'd1,
    WAIT_COIN  = 4'd2,
    ADD        = 4'd3,
    CHECK      = 4'd4,
    DISPENSE   = 4'd5,
    CHANGE     = 4'd6,
    REFUND     = 4'd7,
    CLEAR      = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    BAL_ZERO = 2'd0,
    BAL_ADD  = 2'd1,
    BAL_SUB  = 2'd2,
    BAL_HOLD = 2'd3
  } bal_sel_e;

  localparam logic [1:0] ITEM_10  = 2'd0;
  localparam logic [1:0] ITEM_20  = 2'd1;
  localparam logic [1:0] ITEM_50  = 2'd2;
  localparam logic [1:0] ITEM_100 = 2'd3;

  localparam logic [1:0] COIN_0  = 2'd0;
  localparam logic [1:0] COIN_5  = 2'd1;
  localparam logic [1:0] COIN_10 = 2'd2;
  localparam logic [1:0] COIN_20 = 2'd3;

  function automatic logic [7:0] item_price(input logic [1:0] item);
    logic [7:0] p;
    case (item)
      ITEM_10:  p = 8'd10;
      ITEM_20:  p = 8'd20;
      ITEM_50:  p = 8'd50;
      ITEM_100: p = 8'd100;
      default:  p = 8'd0;
    endcase
    return p;
  endfunction

  function automatic logic [7:0] coin_value(input logic [1:0] coin);
    logic [7:0] v;
    case (coin)
      COIN_0:  v = 8'd0;
      COIN_5:  v = 8'd5;
      COIN_10: v = 8'd10;
      COIN_20: v = 8'd20;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vend_if.sv
// Customer/datapath handshake bundle between the vending controller (slave)
// and its surroundings (master: customer inputs and balance comparator).
interface vend_if;
  logic       start;
  logic [1:0] item_req;
  logic       coin_valid;
  logic [1:0] coin_in;
  logic       cancel;
  logic       lt;
  logic       gt;
  logic       eq;
  logic       ld_item;
  logic       ld_price;
  logic       ld_coin;
  logic       ld_bal;
  logic [1:0] item_sel;
  logic [1:0] coin_sel;
  logic [1:0] bal_sel;
  logic       dispense;
  logic       change;
  logic       refund;
  logic       busy;

  modport master (
    output start, item_req, coin_valid, coin_in, cancel, lt, gt, eq,
    input  ld_item, ld_price, ld_coin, ld_bal, item_sel, coin_sel, bal_sel,
           dispense, change, refund, busy
  );

  modport slave (
    input  start, item_req, coin_valid, coin_in, cancel, lt, gt, eq,
    output ld_item, ld_price, ld_coin, ld_bal, item_sel, coin_sel, bal_sel,
           dispense, change, refund, busy
  );
endinterface

// File: rtl/vend_timer.sv
// Idle-cycle counter for WAIT_COIN; tc flags the last allowed idle cycle.
module vend_timer
  import vend_pkg::*;
#(
  parameter logic [TIMER_W-1:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [TIMER_W-1:0] count_r;

  // Counter register: clear has priority over counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= 8'd0;
    end else if (clear) begin
      count_r <= 8'd0;
    end else if (enable) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == (TIMEOUT_CYCLES - 8'd1));

endmodule

// File: rtl/vend_ctrl.sv
// Vending machine control FSM: sequences item/price load, coin accumulation,
// dispense/change and refund/timeout paths for an external balance datapath.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter logic [TIMER_W-1:0] TIMEOUT_CYCLES = 8'd255
) (
  input logic   clk,
  input logic   reset,
  vend_if.slave bus
);

  state_e state_r;
  state_e next_s;
  logic   chg_flag_r;
  logic   chg_flag_s;
  logic   tmr_clr_s;
  logic   tmr_en_s;
  logic   tmr_tc_s;

  vend_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clr_s),
    .enable (tmr_en_s),
    .tc     (tmr_tc_s)
  );

  // State and change-due flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      chg_flag_r <= 1'b0;
    end else begin
      state_r    <= next_s;
      chg_flag_r <= chg_flag_s;
    end
  end

  // Next-state and output decode; only the item and coin loads are Mealy.
  always_comb begin
    next_s       = state_r;
    chg_flag_s   = chg_flag_r;
    tmr_clr_s    = 1'b0;
    tmr_en_s     = 1'b0;
    bus.ld_item  = 1'b0;
    bus.ld_price = 1'b0;
    bus.ld_coin  = 1'b0;
    bus.ld_bal   = 1'b0;
    bus.item_sel = 2'd0;
    bus.coin_sel = 2'd0;
    bus.bal_sel  = BAL_ZERO;
    bus.dispense = 1'b0;
    bus.change   = 1'b0;
    bus.refund   = 1'b0;
    bus.busy     = (state_r != IDLE);
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          bus.ld_item  = 1'b1;
          bus.item_sel = bus.item_req;
          next_s       = LOAD_PRICE;
        end else begin
          next_s = IDLE;
        end
      end
      LOAD_PRICE: begin
        bus.ld_price = 1'b1;
        bus.ld_bal   = 1'b1;
        bus.bal_sel  = BAL_ZERO;
        tmr_clr_s    = 1'b1;
        next_s       = WAIT_COIN;
      end
      WAIT_COIN: begin
        // Cancel beats a coin arriving in the same cycle; that coin is not loaded.
        if (bus.cancel) begin
          next_s = REFUND;
        end else if (bus.coin_valid) begin
          bus.ld_coin  = 1'b1;
          bus.coin_sel = bus.coin_in;
          tmr_clr_s    = 1'b1;
          next_s       = ADD;
        end else if (tmr_tc_s) begin
          next_s = REFUND;
        end else begin
          tmr_en_s = 1'b1;
          next_s   = WAIT_COIN;
        end
      end
      ADD: begin
        bus.ld_bal  = 1'b1;
        bus.bal_sel = BAL_ADD;
        next_s      = CHECK;
      end
      CHECK: begin
        if (bus.lt) begin
          next_s = WAIT_COIN;
        end else if (bus.eq) begin
          chg_flag_s = 1'b0;
          next_s     = DISPENSE;
        end else if (bus.gt) begin
          chg_flag_s = 1'b1;
          next_s     = DISPENSE;
        end else begin
          next_s = WAIT_COIN;
        end
      end
      DISPENSE: begin
        bus.dispense = 1'b1;
        bus.ld_bal   = 1'b1;
        bus.bal_sel  = BAL_SUB;
        if (chg_flag_r) begin
          next_s = CHANGE;
        end else begin
          next_s = CLEAR;
        end
      end
      CHANGE: begin
        bus.change = 1'b1;
        next_s     = CLEAR;
      end
      REFUND: begin
        bus.refund = 1'b1;
        next_s     = CLEAR;
      end
      CLEAR: begin
        bus.ld_bal  = 1'b1;
        bus.bal_sel = BAL_ZERO;
        chg_flag_s  = 1'b0;
        next_s      = IDLE;
      end
      default: begin
        chg_flag_s = 1'b0;
        next_s     = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl with a small balance datapath model driving lt/gt/eq.
module tb_vend_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  vend_if bus ();

  vend_ctrl #(.TIMEOUT_CYCLES(8'd8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] item_r;
  logic [7:0] price_r;
  logic [7:0] coin_r;
  logic [7:0] bal_r;

  function automatic logic [7:0] tb_price(input logic [1:0] i);
    case (i)
      2'd0:    return 8'd10;
      2'd1:    return 8'd20;
      2'd2:    return 8'd50;
      default: return 8'd100;
    endcase
  endfunction

  function automatic logic [7:0] tb_coin(input logic [1:0] c);
    case (c)
      2'd0:    return 8'd0;
      2'd1:    return 8'd5;
      2'd2:    return 8'd10;
      default: return 8'd20;
    endcase
  endfunction

  // Datapath model controlled by the DUT's load enables and selects.
  always_ff @(posedge clk) begin
    if (reset) begin
      item_r  <= 2'd0;
      price_r <= 8'd0;
      coin_r  <= 8'd0;
      bal_r   <= 8'd0;
    end else begin
      if (bus.ld_item)  item_r  <= bus.item_sel;
      if (bus.ld_price) price_r <= tb_price(item_r);
      if (bus.ld_coin)  coin_r  <= tb_coin(bus.coin_sel);
      if (bus.ld_bal) begin
        case (bus.bal_sel)
          2'd0:    bal_r <= 8'd0;
          2'd1:    bal_r <= bal_r + coin_r;
          2'd2:    bal_r <= bal_r - price_r;
          default: bal_r <= bal_r;
        endcase
      end
    end
  end

  assign bus.lt = (bal_r < price_r);
  assign bus.gt = (bal_r > price_r);
  assign bus.eq = (bal_r == price_r);

  logic [15:0] outs;
  assign outs = {2'd0, bus.busy, bus.ld_item, bus.ld_price, bus.ld_coin, bus.ld_bal,
                 bus.item_sel, bus.coin_sel, bus.bal_sel,
                 bus.dispense, bus.change, bus.refund};

  function automatic logic [15:0] pk(input logic b, input logic li, input logic lp,
                                     input logic lc, input logic lb,
                                     input logic [1:0] is, input logic [1:0] cs,
                                     input logic [1:0] bs, input logic d,
                                     input logic c, input logic r);
    return {2'd0, b, li, lp, lc, lb, is, cs, bs, d, c, r};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: wait for the falling edge, drive inputs, let outputs settle.
  task automatic cy(input logic s, input logic [1:0] it, input logic cv,
                    input logic [1:0] cn, input logic ca);
    @(negedge clk);
    bus.start      = s;
    bus.item_req   = it;
    bus.coin_valid = cv;
    bus.coin_in    = cn;
    bus.cancel     = ca;
    #1;
  endtask

  task automatic begin_txn(input logic [1:0] it, input string tag);
    cy(1'b1, it, 1'b0, 2'd0, 1'b0);
    chk({tag, "_start"}, outs, pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, it, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0));
    cy(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    chk({tag, "_load"}, outs, pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic coin_seq(input logic [1:0] cn, input string tag);
    cy(1'b0, 2'd0, 1'b1, cn, 1'b0);
    chk({tag, "_wait"}, outs, pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, cn, 2'd0, 1'b0, 1'b0, 1'b0));
    cy(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    chk({tag, "_add"}, outs, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0));
    cy(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    chk({tag, "_check"}, outs, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] busy_only;
    logic [15:0] clear_out;
    busy_only = pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    clear_out = pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.item_req = 2'd0; bus.coin_valid = 1'b0;
    bus.coin_in = 2'd0; bus.cancel = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", outs, 16'd0);
    chk("reset_bal", {8'd0, bal_r}, 16'd0);
    reset = 1'b0;

    // item 10, coin 10: exact payment
    begin_txn(2'd0, "t1");
    coin_seq(2'd2, "t1");
    chk("t1_eq", {15'd0, bus.eq}, 16'd1);
    chk("t1_bal_check", {8'd0, bal_r}, 16'd10);
    cy(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    chk("t1_dispense", outs, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0));
    cy(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    chk("t1_clear", outs, clear_out);
    chk("t1_bal_clear", {8'd0, bal_r}, 16'd0);
    cy(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    chk("t1_idle", outs, 16'd0);

    // item 20, coins 5,5,5,20: overpayment with change 15
    begin_txn(2'd1, "t2");
    coin_seq(2'd1, "t2c1");
    chk("t2_lt1", {15'd0, bus.lt}, 16'd1);
    coin_seq(2'd1, "t2c2");
    coin_seq(2'd1, "t2c3");
    chk("t2_bal15", {8'd0, bal_r}, 16'd15);
    coin_seq(2'd3, "t2c4");
    chk("t2_gt", {15'd0, bus.gt}, 16'd1);
    chk("t2_bal35", {8'd0, bal_r}, 16'd35);
    cy(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    chk("t2_dispense", outs, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0));
    cy(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    chk("t2_change", outs, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0));
    chk("t2_bal_change", {8'd0, bal_r}, 16'd15);
    cy(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    chk("t2_clear", outs, clear_out);
    cy(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    chk("t2_idle", outs, 16'd0);

    // item 100, coins 20,20 then cancel
    begin_txn(2'd3, "t3");
    coin_seq(2'd3, "t3c1");
    coin_seq(2'd3, "t3c2");
    cy(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
    chk("t3_cancel", outs, busy_only);
    cy(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    chk("t3_refund", outs, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1));
    chk("t3_bal_refund", {8'd0, bal_r}, 16'd40);
    cy(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    chk("t3_clear", outs, clear_out);
    cy(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    chk("t3_idle", outs, 16'd0);
    chk("t3_bal_idle", {8'd0, bal_r}, 16'd0);

    // item 50, no coins: timeout refund 8 cycles after entering WAIT_COIN
    begin_txn(2'd2, "t4");
    for (int k = 0; k < 8; k++) begin
      cy(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
      chk("t4_wait", outs, busy_only);
    end
    cy(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    chk("t4_refund", outs, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1));
    cy(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    chk("t4_clear", outs, clear_out);
    cy(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    chk("t4_idle", outs, 16'd0);

    // coin and cancel together; start and coin while busy are ignored
    begin_txn(2'd0, "t5");
    cy(1'b0, 2'd0, 1'b1, 2'd3, 1'b1);
    chk("t5_coin_cancel", outs, busy_only);
    cy(1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
    chk("t5_refund_start", outs, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1));
    cy(1'b0, 2'd0, 1'b1, 2'd3, 1'b0);
    chk("t5_clear_coin", outs, clear_out);
    cy(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    chk("t5_idle", outs, 16'd0);
    chk("t5_coin_reg", {8'd0, coin_r}, 16'd20);

    // reset during ADD
    begin_txn(2'd2, "t6");
    cy(1'b0, 2'd0, 1'b1, 2'd3, 1'b0);
    cy(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    chk("t6_add", outs, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0));
    reset = 1'b1;
    cy(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    reset = 1'b0;
    chk("t6_reset_outs", outs, 16'd0);
    chk("t6_reset_bal", {8'd0, bal_r}, 16'd0);
    cy(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    chk("t6_idle", outs, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
